// File: rtl/dc_mem_responder.sv
// Memory-side responder for the data-cache line bus.
// Masked line writes and line reads share one in-order queue and are served from a line-wide array.
module dc_mem_responder #(
  parameter int MWIDTH = 10,
  parameter int QDEPTH = 4,
  parameter int RD_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  output logic         rqfull_1,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         rq_overflow
);

  localparam int PW   = $clog2(QDEPTH);
  localparam int CW   = PW + 1;
  localparam int CNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int EW   = 1 + MWIDTH + 16 + 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RWAIT = 3'd3,
    S_RDATA = 3'd4,
    S_RFIN  = 3'd5
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [EW-1:0]       q_mem_r [QDEPTH];
  logic [PW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]       count_r, count_nxt_s, free_s;
  logic                pop_s, wr_acc_s, rd_acc_s, drop_s;
  logic [EW-1:0]       wr_entry_s, rd_entry_s, head_s;
  logic [MWIDTH-1:0]   cur_idx_r;
  logic [15:0]         cur_mask_r;
  logic [127:0]        cur_data_r;
  logic [CNTW-1:0]     cnt_r;
  logic [127:0]        mem_r [2**MWIDTH];
  logic                mem_we_s, load_s;
  logic                wresp_nxt_s, rvalid_nxt_s, fin_nxt_s;
  logic                unused_addr_s;

  assign wr_entry_s = {1'b1, dcw_in_addr[MWIDTH+3:4], dcw_in_mask, dcw_in_data};
  assign rd_entry_s = {1'b0, dcr_rin_addr[MWIDTH+3:4], {16{1'b0}}, {128{1'b0}}};
  assign head_s     = q_mem_r[rd_ptr_r];
  assign unused_addr_s = ^{dcw_in_addr[31:MWIDTH+4], dcw_in_addr[3:0],
                           dcr_rin_addr[31:MWIDTH+4], dcr_rin_addr[3:0]};

  // Admission: a same-cycle pop frees a slot; the write wins the last free slot over the read
  always_comb begin
    pop_s       = (state_r == S_IDLE) && (count_r != {CW{1'b0}});
    free_s      = CW'(QDEPTH) - count_r + CW'(pop_s);
    wr_acc_s    = dcw_start_rq && (free_s != {CW{1'b0}});
    rd_acc_s    = dcr_start_rq && (free_s > CW'(wr_acc_s));
    drop_s      = (dcw_start_rq && !wr_acc_s) || (dcr_start_rq && !rd_acc_s);
    count_nxt_s = count_r + CW'(wr_acc_s) + CW'(rd_acc_s) - CW'(pop_s);
  end

  // Queue storage; the write lands ahead of a same-cycle read
  always_ff @(posedge clk) begin
    if (wr_acc_s) q_mem_r[wr_ptr_r] <= wr_entry_s;
    if (rd_acc_s) q_mem_r[wr_ptr_r + PW'(wr_acc_s)] <= rd_entry_s;
  end

  // Queue pointers, occupancy, nearly-full flag and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      rqfull_1    <= 1'b0;
      rq_overflow <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_r + PW'(wr_acc_s) + PW'(rd_acc_s);
      rd_ptr_r    <= rd_ptr_r + PW'(pop_s);
      count_r     <= count_nxt_s;
      rqfull_1    <= (count_nxt_s >= CW'(QDEPTH - 1));
      rq_overflow <= rq_overflow | drop_s;
    end
  end

  // FSM state, popped request, read-wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= S_IDLE;
      cnt_r            <= {CNTW{1'b0}};
      cur_idx_r        <= {MWIDTH{1'b0}};
      cur_mask_r       <= {16{1'b1}};
      cur_data_r       <= {128{1'b0}};
      dcw_finish_wresp <= 1'b0;
      rdat_m_valid     <= 1'b0;
      finish_mrd       <= 1'b0;
      rdat_m_data      <= {128{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        cur_idx_r  <= head_s[EW-2 -: MWIDTH];
        cur_mask_r <= head_s[143:128];
        cur_data_r <= head_s[127:0];
        cnt_r      <= CNTW'(RD_LAT - 1);
      end else if (state_r == S_RWAIT) begin
        cnt_r <= cnt_r - CNTW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      dcw_finish_wresp <= wresp_nxt_s;
      rdat_m_valid     <= rvalid_nxt_s;
      finish_mrd       <= fin_nxt_s;
      if (load_s) rdat_m_data <= mem_r[cur_idx_r];
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (pop_s) state_nxt_s = head_s[EW-1] ? S_WR : S_RWAIT;
        else       state_nxt_s = S_IDLE;
      end
      S_WR:    state_nxt_s = S_WRESP;
      S_WRESP: state_nxt_s = S_IDLE;
      S_RWAIT: begin
        if (cnt_r == {CNTW{1'b0}}) state_nxt_s = S_RDATA;
        else                       state_nxt_s = S_RWAIT;
      end
      S_RDATA: state_nxt_s = S_RFIN;
      S_RFIN:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode; pulses are registered from the next state so they align with it
  always_comb begin
    mem_we_s     = (state_r == S_WR) && rst_n;
    load_s       = (state_r == S_RWAIT) && (cnt_r == {CNTW{1'b0}});
    wresp_nxt_s  = (state_nxt_s == S_WRESP);
    rvalid_nxt_s = (state_nxt_s == S_RDATA);
    fin_nxt_s    = (state_nxt_s == S_RFIN);
  end

  // Line array with per-byte enables (mask bit 1 keeps the byte); contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 16; i++) begin
        if (!cur_mask_r[i]) mem_r[cur_idx_r][8*i +: 8] <= cur_data_r[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dc_mem_responder.sv
// Directed testbench for dc_mem_responder: latency, ordering, queue limits, aliasing and reset.
module tb_dc_mem_responder;

  localparam logic [127:0] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2  = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D3C = {16{8'h3C}};
  localparam logic [127:0] DFF = {16{8'hFF}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dcw_start_rq;
  logic [31:0]  dcw_in_addr;
  logic [15:0]  dcw_in_mask;
  logic [127:0] dcw_in_data;
  logic         dcw_finish_wresp;
  logic         dcr_start_rq;
  logic [31:0]  dcr_rin_addr;
  logic         rqfull_1;
  logic [127:0] rdat_m_data;
  logic         rdat_m_valid;
  logic         finish_mrd;
  logic         rq_overflow;

  int n_cmp = 0;
  int n_fail = 0;
  int n_wresp = 0;
  int n_rvalid = 0;
  int n_fin = 0;

  always #5 clk = ~clk;

  dc_mem_responder #(.MWIDTH(10), .QDEPTH(4), .RD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
    .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr), .rqfull_1(rqfull_1),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .rq_overflow(rq_overflow)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (dcw_finish_wresp === 1'b1) n_wresp++;
    if (rdat_m_valid === 1'b1) n_rvalid++;
    if (finish_mrd === 1'b1) n_fin++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  function automatic logic pick(input int which);
    case (which)
      0:       return dcw_finish_wresp;
      1:       return rdat_m_valid;
      default: return finish_mrd;
    endcase
  endfunction

  // Returns the cycle offset at which the selected pulse is seen, or -1 on timeout
  task automatic wait_pulse(input int which, input int start, input int bound, output int lat);
    lat = -1;
    for (int i = start; i <= bound; i++) begin
      if (pick(which) === 1'b1) begin
        lat = i;
        break;
      end
      step();
    end
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d);
    dcw_start_rq = 1'b1; dcw_in_addr = a; dcw_in_mask = m; dcw_in_data = d;
    step();
    dcw_start_rq = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a);
    dcr_start_rq = 1'b1; dcr_rin_addr = a;
    step();
    dcr_start_rq = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drain(2);
    n_cmp++; if (dcw_finish_wresp !== 1'b0) begin n_fail++; $display("FAIL reset_wresp: got %b expected 0", dcw_finish_wresp); end
    n_cmp++; if (rdat_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rdat_m_valid); end
    n_cmp++; if (finish_mrd !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %b expected 0", finish_mrd); end
    n_cmp++; if (rqfull_1 !== 1'b0) begin n_fail++; $display("FAIL reset_rqfull: got %b expected 0", rqfull_1); end
    n_cmp++; if (rq_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", rq_overflow); end
    n_cmp++; if (rdat_m_data !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdat_m_data); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_masked_write_read();
    int lat;
    drain(2);
    issue_write(32'h0000_0120, 16'h0000, D1);
    wait_pulse(0, 1, 10, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr1_latency: got %0d expected 3", lat); end
    issue_write(32'h0000_0120, 16'hFFFE, DFF);
    n_cmp++; if (dcw_finish_wresp !== 1'b0) begin n_fail++; $display("FAIL wresp_width: got %b expected 0", dcw_finish_wresp); end
    wait_pulse(0, 1, 10, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr2_latency: got %0d expected 3", lat); end
    issue_read(32'h0000_012C);
    wait_pulse(1, 1, 20, lat);
    n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL rd_valid_latency: got %0d expected 6", lat); end
    n_cmp++; if (rdat_m_data !== D1) begin n_fail++; $display("FAIL masked_rdata: got %h expected %h", rdat_m_data, D1); end
    step();
    n_cmp++; if (finish_mrd !== 1'b1) begin n_fail++; $display("FAIL rd_fin_t7: got %b expected 1", finish_mrd); end
    n_cmp++; if (rdat_m_valid !== 1'b0) begin n_fail++; $display("FAIL rvalid_width: got %b expected 0", rdat_m_valid); end
    n_cmp++; if (rdat_m_data !== D1) begin n_fail++; $display("FAIL rdata_hold: got %h expected %h", rdat_m_data, D1); end
  endtask

  task automatic test_simultaneous();
    int lat, rv0;
    drain(2);
    rv0 = n_rvalid;
    dcw_start_rq = 1'b1; dcw_in_addr = 32'h0000_0050; dcw_in_mask = 16'h0000; dcw_in_data = DA5;
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_0050;
    step();
    dcw_start_rq = 1'b0; dcr_start_rq = 1'b0;
    wait_pulse(0, 1, 10, lat);
    n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL simul_wresp_latency: got %0d expected 3", lat); end
    n_cmp++; if (n_rvalid !== rv0) begin n_fail++; $display("FAIL simul_order: got %0d reads before wresp expected 0", n_rvalid - rv0); end
    wait_pulse(1, 3, 30, lat);
    n_cmp++; if (lat !== 9) begin n_fail++; $display("FAIL simul_rvalid_latency: got %0d expected 9", lat); end
    n_cmp++; if (rdat_m_data !== DA5) begin n_fail++; $display("FAIL simul_rdata: got %h expected %h", rdat_m_data, DA5); end
    step();
    n_cmp++; if (finish_mrd !== 1'b1) begin n_fail++; $display("FAIL simul_fin: got %b expected 1", finish_mrd); end
  endtask

  task automatic test_queue_fill();
    int fin0, rv0;
    drain(2);
    fin0 = n_fin; rv0 = n_rvalid;
    dcr_start_rq = 1'b1; dcr_rin_addr = 32'h0000_0050;
    drain(3);
    n_cmp++; if (rqfull_1 !== 1'b0) begin n_fail++; $display("FAIL rqfull_occ2: got %b expected 0", rqfull_1); end
    step();
    dcr_start_rq = 1'b0;
    n_cmp++; if (rqfull_1 !== 1'b1) begin n_fail++; $display("FAIL rqfull_occ3: got %b expected 1", rqfull_1); end
    drain(4);
    n_cmp++; if (rqfull_1 !== 1'b1) begin n_fail++; $display("FAIL rqfull_hold: got %b expected 1", rqfull_1); end
    step();
    n_cmp++; if (rqfull_1 !== 1'b0) begin n_fail++; $display("FAIL rqfull_after_pop: got %b expected 0", rqfull_1); end
    n_cmp++; if (rq_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf: got %b expected 0", rq_overflow); end
    drain(40);
    n_cmp++; if (n_fin - fin0 !== 4) begin n_fail++; $display("FAIL fill_fin_count: got %0d expected 4", n_fin - fin0); end
    n_cmp++; if (n_rvalid - rv0 !== 4) begin n_fail++; $display("FAIL fill_rvalid_count: got %0d expected 4", n_rvalid - rv0); end
  endtask

  task automatic test_overflow();
    int wr0, fin0;
    logic [7:0] b;
    drain(3);
    wr0 = n_wresp; fin0 = n_fin;
    issue_read(32'h0000_0050);
    drain(3);
    for (int k = 0; k < 6; k++) begin
      b = 8'(k + 1);
      dcw_start_rq = 1'b1; dcw_in_addr = 32'h0000_0200 + 32'(16 * k);
      dcw_in_mask = 16'h0000; dcw_in_data = {16{b}};
      step();
      if (k == 4) begin
        n_cmp++; if (rq_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_frees_slot: got %b expected 0", rq_overflow); end
      end
      if (k == 5) begin
        n_cmp++; if (rq_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", rq_overflow); end
      end
    end
    dcw_start_rq = 1'b0;
    drain(40);
    n_cmp++; if (n_wresp - wr0 !== 5) begin n_fail++; $display("FAIL ovf_wresp_count: got %0d expected 5", n_wresp - wr0); end
    n_cmp++; if (n_fin - fin0 !== 1) begin n_fail++; $display("FAIL ovf_fin_count: got %0d expected 1", n_fin - fin0); end
    n_cmp++; if (rq_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", rq_overflow); end
  endtask

  task automatic test_alias();
    int lat;
    drain(2);
    issue_write(32'h0000_4010, 16'h0000, D2);
    wait_pulse(0, 1, 10, lat);
    issue_read(32'h0000_0010);
    wait_pulse(1, 1, 20, lat);
    n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL alias_latency: got %0d expected 6", lat); end
    n_cmp++; if (rdat_m_data !== D2) begin n_fail++; $display("FAIL alias_rdata: got %h expected %h", rdat_m_data, D2); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int lat, wr0, rv0, fin0;
    drain(3);
    wr0 = n_wresp; rv0 = n_rvalid; fin0 = n_fin;
    issue_read(32'h0000_0050);
    issue_write(32'h0000_0050, 16'h0000, D3C);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (rqfull_1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rqfull: got %b expected 0", rqfull_1); end
    n_cmp++; if (rq_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b expected 0", rq_overflow); end
    n_cmp++; if (rdat_m_data !== 128'h0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h expected 0", rdat_m_data); end
    drain(15);
    n_cmp++; if (n_rvalid !== rv0) begin n_fail++; $display("FAIL rst_mid_no_rvalid: got %0d pulses expected 0", n_rvalid - rv0); end
    n_cmp++; if (n_fin !== fin0) begin n_fail++; $display("FAIL rst_mid_no_fin: got %0d pulses expected 0", n_fin - fin0); end
    n_cmp++; if (n_wresp !== wr0) begin n_fail++; $display("FAIL rst_mid_no_wresp: got %0d pulses expected 0", n_wresp - wr0); end
    issue_read(32'h0000_0050);
    wait_pulse(1, 1, 20, lat);
    n_cmp++; if (lat !== 6) begin n_fail++; $display("FAIL rst_post_latency: got %0d expected 6", lat); end
    n_cmp++; if (rdat_m_data !== DA5) begin n_fail++; $display("FAIL rst_post_rdata: got %h expected %h", rdat_m_data, DA5); end
    step();
    n_cmp++; if (finish_mrd !== 1'b1) begin n_fail++; $display("FAIL rst_post_fin: got %b expected 1", finish_mrd); end
  endtask

  initial begin
    rst_n = 1'b0;
    dcw_start_rq = 1'b0; dcw_in_addr = 32'h0; dcw_in_mask = 16'hFFFF; dcw_in_data = 128'h0;
    dcr_start_rq = 1'b0; dcr_rin_addr = 32'h0;
    test_reset();
    test_masked_write_read();
    test_simultaneous();
    test_queue_fill();
    test_overflow();
    test_alias();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
